regfile_scoreboard: RTL and testbench

Decode-side receiver of the writeback interface. Holds the 16-entry architectural register file, accepts one writeback per cycle, and serves two combinational source-read ports to decode. Tracks in-flight destination writes with per-register pending counters and drives O_DepStall to decode/fetch on RAW hazards.

---
 rtl/regfile_scoreboard_pkg.sv | 19 +
 rtl/regfile_scoreboard_sb_pending_ctr.sv | 58 +++++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared sizing for the decode-side register file and its RAW scoreboard.
//   REG_WIDTH  : architectural data width (mirrors the global REG_WIDTH define)
//   NUM_REGS   : architectural register count
//   IDX_WIDTH  : register index width
//   PEND_WIDTH : width of each per-register in-flight write counter
//   PEND_MAX   : most in-flight writes one register can track
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int NUM_REGS   = 16;
    localparam int IDX_WIDTH  = 4;
    localparam int PEND_WIDTH = 2;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

endpackage

// File: rtl/regfile_scoreboard_sb_pending_ctr.sv
// -----------------------------------------------------------------------------
// sb_pending_ctr
// Saturating up/down counter holding the number of in-flight writes to one
// architectural register.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   en_i    : pipeline enable; 0 holds the count and suppresses err_o
//   inc_i   : an issued instruction targets this register
//   dec_i   : a writeback to this register completes
//   count_o : current in-flight count
//   err_o   : one-cycle pulse on an attempted overflow or underflow
// -----------------------------------------------------------------------------
module sb_pending_ctr
    import regfile_scoreboard_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [PEND_WIDTH-1:0] count_o,
    output logic                  err_o
);

    logic [PEND_WIDTH-1:0] count_q;
    logic [PEND_WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise a latch is inferred.
        count_d = count_q;
        err_o   = 1'b0;
        if (en_i) begin
            // A simultaneous inc and dec cancel out and leave the count alone.
            unique case ({inc_i, dec_i})
                2'b10: begin
                    if (count_q == PEND_MAX) err_o   = 1'b1;
                    else                     count_d = count_q + 1'b1;
                end
                2'b01: begin
                    if (count_q == '0) err_o   = 1'b1;
                    else               count_d = count_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// 16-entry architectural register file with one writeback port, two
// combinational read ports, and a per-register pending-write scoreboard that
// raises O_DepStall on RAW hazards and on a full pending counter.
//   I_CLOCK / I_RESET             : clock, async active-high reset
//   I_LOCK                        : pipeline enable (0 freezes all state)
//   I_WriteBackEnable/RegIdx/Data : writeback port
//   I_Src{1,2}Idx / I_Src{1,2}Valid : decode source reads
//   I_IssueValid / I_IssueDestIdx : register-writing instruction issuing
//   O_Src{1,2}Data                : source operands, zero latency
//   O_DepStall                    : hazard stall to decode/fetch
//   O_PendingMask                 : bit i set while register i has writes in flight
//   O_ScoreboardError             : sticky counter over/underflow flag
// Build option: define WB_BYPASS_EN to forward the writeback value to the read
// ports and release a source whose last outstanding write lands this cycle.
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_LOCK,
    input  logic                 I_WriteBackEnable,
    input  logic [IDX_WIDTH-1:0] I_WriteBackRegIdx,
    input  logic [REG_WIDTH-1:0] I_WriteBackData,
    input  logic [IDX_WIDTH-1:0] I_Src1Idx,
    input  logic [IDX_WIDTH-1:0] I_Src2Idx,
    input  logic                 I_Src1Valid,
    input  logic                 I_Src2Valid,
    input  logic                 I_IssueValid,
    input  logic [IDX_WIDTH-1:0] I_IssueDestIdx,
    output logic [REG_WIDTH-1:0] O_Src1Data,
    output logic [REG_WIDTH-1:0] O_Src2Data,
    output logic                 O_DepStall,
    output logic [NUM_REGS-1:0]  O_PendingMask,
    output logic                 O_ScoreboardError
);

    logic [REG_WIDTH-1:0]  rf_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend [NUM_REGS];
    logic [NUM_REGS-1:0]   ctr_err;
    logic                  err_q;
    logic                  err_d;
    logic                  wb_fire;
    logic                  issue_accept;
    logic                  busy1;
    logic                  busy2;

    assign wb_fire      = I_LOCK & I_WriteBackEnable;
    assign issue_accept = I_LOCK & I_IssueValid & ~O_DepStall;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
        sb_pending_ctr u_ctr (
            .clk_i   (I_CLOCK),
            .rst_i   (I_RESET),
            .en_i    (I_LOCK),
            .inc_i   (issue_accept && (I_IssueDestIdx == IDX_WIDTH'(i))),
            .dec_i   (wb_fire && (I_WriteBackRegIdx == IDX_WIDTH'(i))),
            .count_o (pend[i]),
            .err_o   (ctr_err[i])
        );
        assign O_PendingMask[i] = (pend[i] != '0);
    end

    // NOTE: the register array is reset because the decode side must read
    // zeros right after reset; that costs a reset net on every entry.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
        end else if (wb_fire) begin
            rf_q[I_WriteBackRegIdx] <= I_WriteBackData;
        end
    end

    assign err_d = err_q | (|ctr_err);

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign O_ScoreboardError = err_q;

    always_comb begin
        O_Src1Data = rf_q[I_Src1Idx];
        O_Src2Data = rf_q[I_Src2Idx];
        busy1      = I_Src1Valid && (pend[I_Src1Idx] != '0);
        busy2      = I_Src2Valid && (pend[I_Src2Idx] != '0);
`ifdef WB_BYPASS_EN
        // The landing writeback satisfies a reader only when it is the last
        // write still outstanding to that register.
        if (I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1Idx)) begin
            O_Src1Data = I_WriteBackData;
            if (pend[I_Src1Idx] == PEND_WIDTH'(1)) busy1 = 1'b0;
        end
        if (I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2Idx)) begin
            O_Src2Data = I_WriteBackData;
            if (pend[I_Src2Idx] == PEND_WIDTH'(1)) busy2 = 1'b0;
        end
`else
        // Without forwarding a reader waits until the cycle after the RF write.
`endif
        O_DepStall = I_LOCK && (busy1 || busy2 ||
                     (I_IssueValid && (pend[I_IssueDestIdx] == PEND_MAX)));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed bench for regfile_scoreboard: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 lock;
    logic                 wb_en;
    logic [IDX_WIDTH-1:0] wb_idx;
    logic [REG_WIDTH-1:0] wb_data;
    logic [IDX_WIDTH-1:0] s1_idx;
    logic [IDX_WIDTH-1:0] s2_idx;
    logic                 s1_v;
    logic                 s2_v;
    logic                 iss_v;
    logic [IDX_WIDTH-1:0] iss_idx;
    logic [REG_WIDTH-1:0] s1_data;
    logic [REG_WIDTH-1:0] s2_data;
    logic                 stall;
    logic [NUM_REGS-1:0]  mask;
    logic                 err;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard dut (
        .I_CLOCK           (clk),
        .I_RESET           (rst),
        .I_LOCK            (lock),
        .I_WriteBackEnable (wb_en),
        .I_WriteBackRegIdx (wb_idx),
        .I_WriteBackData   (wb_data),
        .I_Src1Idx         (s1_idx),
        .I_Src2Idx         (s2_idx),
        .I_Src1Valid       (s1_v),
        .I_Src2Valid       (s2_v),
        .I_IssueValid      (iss_v),
        .I_IssueDestIdx    (iss_idx),
        .O_Src1Data        (s1_data),
        .O_Src2Data        (s2_data),
        .O_DepStall        (stall),
        .O_PendingMask     (mask),
        .O_ScoreboardError (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic [3:0]  wb_idx;
        logic [31:0] wb_data;
        logic [3:0]  s1_idx;
        logic        s1_v;
        logic [3:0]  s2_idx;
        logic        s2_v;
        logic        iss_v;
        logic [3:0]  iss_idx;
        logic [31:0] exp_s1;
        logic [31:0] exp_s2;
        logic        exp_stall;
        logic [15:0] exp_mask;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_idx = '0; wb_data = '0;
        s1_idx = '0; s1_v = 1'b0; s2_idx = '0; s2_v = 1'b0;
        iss_v = 1'b0; iss_idx = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] idx);
        idle();
        iss_v = 1'b1; iss_idx = idx;
        step();
        idle();
    endtask

    task automatic wb(input logic [3:0] idx, input logic [31:0] data);
        idle();
        wb_en = 1'b1; wb_idx = idx; wb_data = data;
        step();
        idle();
    endtask

    initial begin
        //            wb  idx  data          s1  v   s2  v   iv  iidx  exp_s1        exp_s2        stl mask     err
        vecs[0] = '{1'b0, 4'd0, 32'h0,        4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 32'h0,        32'h0,        1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 4'd0, 32'h0,        4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 32'h0,        32'h0,        1'b0, 16'h0002, 1'b0};
        vecs[2] = '{1'b1, 4'd1, 32'h11,       4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0,        1'b1, 16'h0006, 1'b0};
        vecs[3] = '{1'b1, 4'd2, 32'h22,       4'd1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 32'h11,       32'h0,        1'b0, 16'h0004, 1'b0};
        vecs[4] = '{1'b0, 4'd0, 32'h0,        4'd2, 1'b1, 4'd1, 1'b1, 1'b1, 4'd0, 32'h22,       32'h11,       1'b0, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 4'd0, 32'h0,        4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 32'h0,        32'h0,        1'b1, 16'h0001, 1'b0};
        vecs[6] = '{1'b1, 4'd0, 32'hCAFE,     4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 32'h11,       32'h0,        1'b0, 16'h0001, 1'b0};
        vecs[7] = '{1'b0, 4'd0, 32'h0,        4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 32'hCAFE,     32'h22,       1'b0, 16'h0000, 1'b0};

        rst = 1'b1; lock = 1'b1; idle();
        #1;
        check("reset_s1", s1_data, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_mask", {16'b0, mask}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        step(); step();
        rst = 1'b0;
        step();

        // Table: outputs checked before the edge that commits each vector.
        for (int i = 0; i < 8; i++) begin
            wb_en = vecs[i].wb_en; wb_idx = vecs[i].wb_idx; wb_data = vecs[i].wb_data;
            s1_idx = vecs[i].s1_idx; s1_v = vecs[i].s1_v;
            s2_idx = vecs[i].s2_idx; s2_v = vecs[i].s2_v;
            iss_v = vecs[i].iss_v; iss_idx = vecs[i].iss_idx;
            #1;
            check($sformatf("vec%0d_s1", i), s1_data, vecs[i].exp_s1);
            check($sformatf("vec%0d_s2", i), s2_data, vecs[i].exp_s2);
            check($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            check($sformatf("vec%0d_mask", i), {16'b0, mask}, {16'b0, vecs[i].exp_mask});
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            step();
        end
        idle();

        // RAW on R5 resolved by a writeback.
        issue(4'd5);
        s1_idx = 4'd5; s1_v = 1'b1; #1;
        check("r5_raw_stall", {31'b0, stall}, 32'h1);
        step();
        wb_en = 1'b1; wb_idx = 4'd5; wb_data = 32'hDEADBEEF; #1;
`ifdef WB_BYPASS_EN
        check("r5_wb_stall", {31'b0, stall}, 32'h0);
        check("r5_wb_data", s1_data, 32'hDEADBEEF);
`else
        check("r5_wb_stall", {31'b0, stall}, 32'h1);
        check("r5_wb_data", s1_data, 32'h0);
`endif
        step();
        wb_en = 1'b0; #1;
        check("r5_after_stall", {31'b0, stall}, 32'h0);
        check("r5_after_data", s1_data, 32'hDEADBEEF);
        idle();

        // Pending-counter saturation on R7.
        issue(4'd7); issue(4'd7); issue(4'd7);
        iss_v = 1'b1; iss_idx = 4'd7; #1;
        check("r7_full_stall", {31'b0, stall}, 32'h1);
        check("r7_full_mask", {16'b0, mask}, 32'h0080);
        check("r7_full_err", {31'b0, err}, 32'h0);
        step();
        wb_en = 1'b1; wb_idx = 4'd7; wb_data = 32'h77; #1;
        check("r7_wb_cycle_stall", {31'b0, stall}, 32'h1);
        step();
        wb_en = 1'b0; #1;
        check("r7_retry_stall", {31'b0, stall}, 32'h0);
        step();
        idle();
        wb(4'd7, 32'h71); wb(4'd7, 32'h72);
        #1;
        check("r7_drain2_mask", {16'b0, mask}, 32'h0080);
        wb(4'd7, 32'h73);
        #1;
        check("r7_drained_mask", {16'b0, mask}, 32'h0000);
        check("r7_drained_err", {31'b0, err}, 32'h0);

        // Same-cycle issue and writeback to R2.
        issue(4'd2);
        iss_v = 1'b1; iss_idx = 4'd2; wb_en = 1'b1; wb_idx = 4'd2; wb_data = 32'h55; #1;
        check("r2_same_stall", {31'b0, stall}, 32'h0);
        step();
        idle(); s1_idx = 4'd2; #1;
        check("r2_same_mask", {16'b0, mask}, 32'h0004);
        check("r2_same_data", s1_data, 32'h55);
        wb(4'd2, 32'h55);
        #1;
        check("r2_clear_mask", {16'b0, mask}, 32'h0000);
        check("r2_clear_err", {31'b0, err}, 32'h0);

        // Frozen pipeline.
        lock = 1'b0;
        wb_en = 1'b1; wb_idx = 4'd1; wb_data = 32'hFF;
        iss_v = 1'b1; iss_idx = 4'd1; s1_idx = 4'd1; s1_v = 1'b1; #1;
        check("lock_stall", {31'b0, stall}, 32'h0);
        step();
        lock = 1'b1; idle(); s1_idx = 4'd1; #1;
        check("lock_data", s1_data, 32'h11);
        check("lock_mask", {16'b0, mask}, 32'h0000);
        check("lock_err", {31'b0, err}, 32'h0);

        // Underflowing writeback to R9 sets the sticky error.
        wb_en = 1'b1; wb_idx = 4'd9; wb_data = 32'hA5; #1;
        check("r9_pre_err", {31'b0, err}, 32'h0);
        step();
        idle(); s1_idx = 4'd9; #1;
        check("r9_data", s1_data, 32'hA5);
        check("r9_err", {31'b0, err}, 32'h1);
        step(); step();
        check("r9_err_sticky", {31'b0, err}, 32'h1);

        // Asynchronous reset with R3 = 0x1234 and two writes pending.
        issue(4'd3); issue(4'd3); issue(4'd3);
        wb(4'd3, 32'h1234);
        s1_idx = 4'd3; s1_v = 1'b1; #1;
        check("r3_pre_data", s1_data, 32'h1234);
        check("r3_pre_stall", {31'b0, stall}, 32'h1);
        #2;
        rst = 1'b1; #1;
        check("rst_r3_data", s1_data, 32'h0);
        check("rst_mask", {16'b0, mask}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        step();
        rst = 1'b0; idle();
        step();
        wb(4'd3, 32'h3333);
        s1_idx = 4'd3; #1;
        check("stale_wb_data", s1_data, 32'h3333);
        check("stale_wb_err", {31'b0, err}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
